// File: rtl/odpc_range_clamp.sv
// Two-stage range clamp for multi-lane words: S1 captures the input beat, S2 holds the clamped
// value and LBP1/LBP2 flags. A saturating fault counter and sticky bound errors update on output handshake.
module odpc_range_clamp #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mode,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_x,
   input  logic [LANES*WIDTH-1:0] max,
   input  logic [LANES*WIDTH-1:0] min,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_x,
   output logic [LANES*WIDTH-1:0] lbp1,
   output logic [LANES*WIDTH-1:0] lbp2,
   output logic [CNT_W-1:0]       fault_cnt,
   input  logic                   fault_clr,
   output logic [LANES-1:0]       bound_err
);

   localparam int DW = LANES * WIDTH;

   logic            s1_valid_q, s1_valid_d;
   logic            s1_mode_q, s1_mode_d;
   logic [DW-1:0]   s1_x_q, s1_x_d;
   logic [DW-1:0]   s1_max_q, s1_max_d;
   logic [DW-1:0]   s1_min_q, s1_min_d;

   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_x_q, out_x_d;
   logic [DW-1:0]   lbp1_q, lbp1_d;
   logic [DW-1:0]   lbp2_q, lbp2_d;
   logic [LANES-1:0] s2_berr_q, s2_berr_d;

   logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
   logic [LANES-1:0] bound_err_q, bound_err_d;

   logic            s2_adv;
   logic            in_hs;
   logic            out_hs;
   logic [DW-1:0]   cmp_x, cmp_l1, cmp_l2;
   logic [LANES-1:0] cmp_berr;
   logic [CNT_W:0]  nflag;
   logic [CNT_W:0]  cnt_sum;

   assign s2_adv   = !out_valid_q || out_ready;
   assign in_ready = rst_n && (!s1_valid_q || s2_adv);
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;

   always_comb begin
      cmp_x    = s1_x_q;
      cmp_l1   = '0;
      cmp_l2   = '0;
      cmp_berr = '0;
      for (int k = 0; k < LANES; k++) begin
         if (s1_mode_q) begin
            cmp_l1[k*WIDTH +: WIDTH] = s1_x_q[k*WIDTH +: WIDTH] & ~s1_max_q[k*WIDTH +: WIDTH];
            cmp_l2[k*WIDTH +: WIDTH] = ~s1_x_q[k*WIDTH +: WIDTH] & s1_min_q[k*WIDTH +: WIDTH];
            cmp_x[k*WIDTH +: WIDTH]  = (s1_x_q[k*WIDTH +: WIDTH] | s1_min_q[k*WIDTH +: WIDTH])
                                       & s1_max_q[k*WIDTH +: WIDTH];
         end else if (s1_min_q[k*WIDTH +: WIDTH] > s1_max_q[k*WIDTH +: WIDTH]) begin
            // Inverted bounds: pass data through unflagged, remember it for the sticky error.
            cmp_berr[k] = 1'b1;
         end else if (s1_x_q[k*WIDTH +: WIDTH] > s1_max_q[k*WIDTH +: WIDTH]) begin
            cmp_x[k*WIDTH +: WIDTH]  = s1_max_q[k*WIDTH +: WIDTH];
            cmp_l1[k*WIDTH +: WIDTH] = '1;
         end else if (s1_x_q[k*WIDTH +: WIDTH] < s1_min_q[k*WIDTH +: WIDTH]) begin
            cmp_x[k*WIDTH +: WIDTH]  = s1_min_q[k*WIDTH +: WIDTH];
            cmp_l2[k*WIDTH +: WIDTH] = '1;
         end
      end
   end

   always_comb begin
      nflag = '0;
      for (int k = 0; k < LANES; k++) begin
         if ((|lbp1_q[k*WIDTH +: WIDTH]) || (|lbp2_q[k*WIDTH +: WIDTH])) begin
            nflag = nflag + {{CNT_W{1'b0}}, 1'b1};
         end
      end
      cnt_sum = {1'b0, fault_cnt_q} + nflag;
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_mode_d   = s1_mode_q;
      s1_x_d      = s1_x_q;
      s1_max_d    = s1_max_q;
      s1_min_d    = s1_min_q;
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      lbp1_d      = lbp1_q;
      lbp2_d      = lbp2_q;
      s2_berr_d   = s2_berr_q;
      fault_cnt_d = fault_cnt_q;
      bound_err_d = bound_err_q;

      if (in_hs) begin
         s1_valid_d = 1'b1;
         s1_mode_d  = mode;
         s1_x_d     = in_x;
         s1_max_d   = max;
         s1_min_d   = min;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_x_d   = cmp_x;
            lbp1_d    = cmp_l1;
            lbp2_d    = cmp_l2;
            s2_berr_d = cmp_berr;
         end
      end

      if (fault_clr) begin
         fault_cnt_d = '0;
         bound_err_d = '0;
      end else if (out_hs) begin
         fault_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
         bound_err_d = bound_err_q | s2_berr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_mode_q   <= 1'b0;
         s1_x_q      <= '0;
         s1_max_q    <= '0;
         s1_min_q    <= '0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         lbp1_q      <= '0;
         lbp2_q      <= '0;
         s2_berr_q   <= '0;
         fault_cnt_q <= '0;
         bound_err_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_mode_q   <= s1_mode_d;
         s1_x_q      <= s1_x_d;
         s1_max_q    <= s1_max_d;
         s1_min_q    <= s1_min_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         lbp1_q      <= lbp1_d;
         lbp2_q      <= lbp2_d;
         s2_berr_q   <= s2_berr_d;
         fault_cnt_q <= fault_cnt_d;
         bound_err_q <= bound_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign lbp1      = lbp1_q;
   assign lbp2      = lbp2_q;
   assign fault_cnt = fault_cnt_q;
   assign bound_err = bound_err_q;

endmodule

// File: tb/tb_odpc_range_clamp.sv
// Scoreboard bench for odpc_range_clamp (8-bit x 4 lanes, 4-bit fault counter): directed cases
// from the block's behaviour plus randomized beats checked against a lane-level reference model.
module tb_odpc_range_clamp;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] l1;
      logic [31:0] l2;
      logic [3:0]  berr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, mode, in_valid, in_ready, out_valid, out_ready, fault_clr;
   logic [31:0] in_x, max_v, min_v, out_x, lbp1, lbp2;
   logic [3:0]  fault_cnt, bound_err;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   bit   rand_en = 1'b0;

   int          m_cnt = 0;
   logic [3:0]  m_berr = '0;
   exp_t        m_e;
   int          m_nf;
   bit          prev_stall = 1'b0;
   logic [31:0] px, pl1, pl2;

   always #5 clk = ~clk;

   odpc_range_clamp #(.WIDTH(8), .LANES(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .max(max_v), .min(min_v), .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .lbp1(lbp1), .lbp2(lbp2), .fault_cnt(fault_cnt), .fault_clr(fault_clr),
      .bound_err(bound_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   // Lane-level reference: unsigned integer comparison for word mode, bitwise rules for bit mode.
   function automatic exp_t model(input logic m, input logic [31:0] x, input logic [31:0] mx,
                                  input logic [31:0] mn);
      exp_t e;
      int   xi, hi, lo;
      e = '0;
      for (int k = 0; k < 4; k++) begin
         xi = int'(x[k*8 +: 8]);
         hi = int'(mx[k*8 +: 8]);
         lo = int'(mn[k*8 +: 8]);
         if (m) begin
            for (int b = 0; b < 8; b++) begin
               e.l1[k*8+b] = x[k*8+b] && !mx[k*8+b];
               e.l2[k*8+b] = !x[k*8+b] && mn[k*8+b];
               e.x[k*8+b]  = mx[k*8+b] ? (x[k*8+b] || mn[k*8+b]) : 1'b0;
            end
         end else if (lo > hi) begin
            e.x[k*8 +: 8] = 8'(xi);
            e.berr[k]     = 1'b1;
         end else if (xi > hi) begin
            e.x[k*8 +: 8]  = 8'(hi);
            e.l1[k*8 +: 8] = 8'hFF;
         end else if (xi < lo) begin
            e.x[k*8 +: 8]  = 8'(lo);
            e.l2[k*8 +: 8] = 8'hFF;
         end else begin
            e.x[k*8 +: 8] = 8'(xi);
         end
      end
      return e;
   endfunction

   // Called #1 after a rising edge; returns #1 after the edge that captured the beat.
   task automatic send(input logic m, input logic [31:0] x, input logic [31:0] mx,
                       input logic [31:0] mn, input exp_t e);
      int t = 0;
      in_valid = 1'b1; mode = m; in_x = x; max_v = mx; min_v = mn;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 300) break;
      end
      if (in_ready) q.push_back(e);
      else fail_now("accept timeout");
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic m, input logic [31:0] x, input logic [31:0] mx,
                         input logic [31:0] mn);
      send(m, x, mx, mn, model(m, x, mx, mn));
   endtask

   task automatic send_rand();
      logic [31:0] x, mx, mn;
      logic [7:0]  a, b;
      x = $urandom;
      for (int k = 0; k < 4; k++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0 && a < b) begin
            mx[k*8 +: 8] = b; mn[k*8 +: 8] = a;
         end else begin
            mx[k*8 +: 8] = a; mn[k*8 +: 8] = b;
         end
      end
      send_m(1'($urandom_range(0, 1)), x, mx, mn);
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) fail_now("drain timeout");
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: model state reflects edges already taken; handshake effects applied for the next edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_cnt = 0;
         m_berr = '0;
         prev_stall = 1'b0;
      end else begin
         chk("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
         chk("bound_err", 32'(bound_err), 32'(m_berr));
         if (prev_stall) begin
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall out_x", out_x, px);
            chk("stall lbp1", lbp1, pl1);
            chk("stall lbp2", lbp2, pl2);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               fail_now("unexpected output beat");
            end else begin
               m_e = q.pop_front();
               chk("out_x", out_x, m_e.x);
               chk("lbp1", lbp1, m_e.l1);
               chk("lbp2", lbp2, m_e.l2);
               m_nf = 0;
               for (int k = 0; k < 4; k++)
                  if (m_e.l1[k*8 +: 8] != 8'h00 || m_e.l2[k*8 +: 8] != 8'h00) m_nf++;
               m_cnt = (m_cnt + m_nf > 15) ? 15 : m_cnt + m_nf;
               m_berr = m_berr | m_e.berr;
            end
         end
         if (fault_clr) begin
            m_cnt = 0;
            m_berr = '0;
         end
         prev_stall = out_valid && !out_ready;
         px = out_x; pl1 = lbp1; pl2 = lbp2;
      end
   end

   always begin
      @(posedge clk); #1;
      if (rand_en) begin
         out_ready = ($urandom_range(0, 9) < 7);
         fault_clr = ($urandom_range(0, 59) == 0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_drop;
      rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; in_x = '0; max_v = '0; min_v = '0;
      out_ready = 1'b1; fault_clr = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_x", out_x, 32'd0);
      chk("rst lbp1", lbp1, 32'd0);
      chk("rst lbp2", lbp2, 32'd0);
      chk("rst fault_cnt", 32'(fault_cnt), 32'd0);
      chk("rst bound_err", 32'(bound_err), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-rst in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Word mode clamp and two-cycle latency
      send(1'b0, 32'h40058010, 32'h60606060, 32'h08080808,
           {32'h40086010, 32'h0000FF00, 32'h00FF0000, 4'b0000});
      @(negedge clk);
      chk("latency n+1 out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency n+2 out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("word fault_cnt", 32'(fault_cnt), 32'd2);
      @(posedge clk); #1;

      // Bit mode
      send(1'b1, 32'h000000AC, 32'hFFFFFFE6, 32'h00000014,
           {32'h000000A4, 32'h00000008, 32'h00000010, 4'b0000});
      drain();
      @(negedge clk);
      chk("bit fault_cnt", 32'(fault_cnt), 32'd3);
      @(posedge clk); #1;

      // Inverted bounds: sticky bound error until cleared
      send(1'b0, 32'h10101033, 32'hFFFFFF20, 32'h00000050,
           {32'h10101033, 32'h0, 32'h0, 4'b0001});
      drain();
      @(negedge clk);
      chk("bound_err set", 32'(bound_err), 32'd1);
      @(posedge clk); #1;
      send_m(1'b0, 32'h11111111, 32'hFFFFFFFF, 32'h00000000);
      drain();
      @(negedge clk);
      chk("bound_err sticky", 32'(bound_err), 32'd1);
      @(posedge clk); #1;
      fault_clr = 1'b1;
      @(posedge clk); #1;
      fault_clr = 1'b0;
      @(negedge clk);
      chk("clr bound_err", 32'(bound_err), 32'd0);
      chk("clr fault_cnt", 32'(fault_cnt), 32'd0);
      @(posedge clk); #1;

      // Backpressure mid-stream
      saw_drop = 1'b0;
      fork
         for (int i = 0; i < 5; i++) send_m(1'b0, $urandom, 32'hC0C0C0C0, 32'h30303030);
         begin
            repeat (2) @(posedge clk); #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk); #1;
            out_ready = 1'b1;
         end
         repeat (10) begin
            @(negedge clk);
            if (!in_ready) saw_drop = 1'b1;
         end
      join
      drain();
      chk("in_ready dropped", 32'(saw_drop), 32'd1);

      // Saturation, then clear on a handshake edge with flagged lanes
      for (int i = 0; i < 5; i++) send_m(1'b0, 32'hFFFFFFFF, 32'h10101010, 32'h00000000);
      drain();
      @(negedge clk);
      chk("saturated fault_cnt", 32'(fault_cnt), 32'd15);
      @(posedge clk); #1;
      out_ready = 1'b0;
      send_m(1'b0, 32'hFFFFFFFF, 32'h10101010, 32'h00000000);
      @(posedge clk); #1;
      out_ready = 1'b1;
      fault_clr = 1'b1;
      @(posedge clk); #1;
      fault_clr = 1'b0;
      @(negedge clk);
      chk("clr wins fault_cnt", 32'(fault_cnt), 32'd0);
      @(posedge clk); #1;

      // Randomized traffic with random backpressure and occasional clears
      rand_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send_rand();
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      rand_en = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      fault_clr = 1'b0;
      drain();

      // Reset with two beats in flight
      send_m(1'b0, 32'hFFFFFFFF, 32'h10101020, 32'h00000050);
      drain();
      out_ready = 1'b0;
      send_m(1'b0, 32'hFFFFFFFF, 32'h10101010, 32'h00000000);
      send_m(1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h40404040);
      rst_n = 1'b0;
      @(negedge clk);
      chk("in_ready during reset", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("mid-rst out_valid", 32'(out_valid), 32'd0);
      chk("mid-rst fault_cnt", 32'(fault_cnt), 32'd0);
      chk("mid-rst bound_err", 32'(bound_err), 32'd0);
      chk("mid-rst in_ready", 32'(in_ready), 32'd1);
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
